// File: rtl/word_segmenter_if.sv
// Sample-in / word-out bus for word_segmenter.
//
// Handshake: the input side has no backpressure. A sample (iidx, idata, ilast)
// is consumed on every rising edge where ivalid=1. On the output side a result
// (ostart_idx, oend_idx, olen) transfers on every rising edge where ovalid=1
// and iready=1. While ovalid=1 and iready=0 every result field holds steady.
// oshort is a one-cycle pulse and ooverflow is sticky; neither takes part in
// the handshake. dbg_state mirrors the detector FSM state.
interface word_segmenter_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 32
);
  logic              ivalid;
  logic              ilast;
  logic [IDX_W-1:0]  iidx;
  logic [DATA_W-1:0] idata;
  logic              iready;
  logic              ovalid;
  logic [IDX_W-1:0]  ostart_idx;
  logic [IDX_W-1:0]  oend_idx;
  logic [IDX_W-1:0]  olen;
  logic              oshort;
  logic              ooverflow;
  logic [1:0]        dbg_state;

  modport master (
    output ivalid, ilast, iidx, idata, iready,
    input  ovalid, ostart_idx, oend_idx, olen, oshort, ooverflow, dbg_state
  );

  modport slave (
    input  ivalid, ilast, iidx, idata, iready,
    output ovalid, ostart_idx, oend_idx, olen, oshort, ooverflow, dbg_state
  );
endinterface

// File: rtl/word_segmenter.sv
// Word boundary detector with dual-threshold hysteresis, hangover bridging,
// minimum-length rejection, pre-roll padding and a one-deep result register.
module word_segmenter #(
  parameter int                DATA_W          = 16,
  parameter int                IDX_W           = 32,
  parameter bit                SIGNED          = 1'b1,
  parameter logic [DATA_W-1:0] LOWER_THRESHOLD = DATA_W'(16'h0042),
  parameter logic [DATA_W-1:0] UPPER_THRESHOLD = DATA_W'(16'h0294),
  parameter int                HANGOVER        = 64,
  parameter int                MIN_LEN         = 256,
  parameter int                PRE_ROLL        = 0
) (
  input logic             iclk,
  input logic             irst,
  word_segmenter_if.slave bus
);

  localparam logic [15:0]       HANG_N  = 16'(HANGOVER);
  localparam logic [IDX_W-1:0]  MIN_N   = IDX_W'(MIN_LEN);
  localparam logic [IDX_W-1:0]  PRE_N   = IDX_W'(PRE_ROLL);
  localparam logic [DATA_W-1:0] NEG_MAX = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  // IDLE: silence. ARMED: above lower, waiting for an upper crossing.
  // ACTIVE: confirmed word. HANG: counting quiet samples after the word.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2,
    S_HANG   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  start_q, start_nxt;
  logic [IDX_W-1:0]  cand_end_q, cand_end_nxt;
  logic [15:0]       cnt_q, cnt_nxt;
  logic [DATA_W-1:0] mag;
  logic              above_up, above_lo, quiet;
  logic              fin;
  logic [IDX_W-1:0]  fin_end;
  logic [IDX_W-1:0]  raw_len;
  logic [IDX_W:0]    pad_diff;
  logic [IDX_W-1:0]  pad_start;
  logic              load, reject;

  logic              ovalid_q, oshort_q, ooverflow_q;
  logic [IDX_W-1:0]  ostart_q, oend_q, olen_q;

  // Sample magnitude; the most negative code saturates to the largest positive.
  always_comb begin : magnitude
    mag = bus.idata;
    if (SIGNED && bus.idata[DATA_W-1]) begin
      if (bus.idata == NEG_MAX) mag = POS_MAX;
      else                      mag = -bus.idata;
    end
  end

  assign above_up = (mag > UPPER_THRESHOLD);
  assign above_lo = (mag > LOWER_THRESHOLD);
  assign quiet    = (mag < LOWER_THRESHOLD);

  // FSM state and word-tracking registers.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state      <= S_IDLE;
      start_q    <= '0;
      cand_end_q <= '0;
      cnt_q      <= '0;
    end else begin
      state      <= state_nxt;
      start_q    <= start_nxt;
      cand_end_q <= cand_end_nxt;
      cnt_q      <= cnt_nxt;
    end
  end

  // Next state; only samples with ivalid=1 move the FSM.
  always_comb begin : next_state
    state_nxt    = state;
    start_nxt    = start_q;
    cand_end_nxt = cand_end_q;
    cnt_nxt      = cnt_q;
    fin          = 1'b0;
    fin_end      = cand_end_q;
    if (bus.ivalid) begin
      case (state)
        S_IDLE: begin
          if (above_up) begin
            state_nxt = S_ACTIVE;
            start_nxt = bus.iidx;
          end else if (above_lo) begin
            state_nxt = S_ARMED;
            start_nxt = bus.iidx;
          end
        end
        S_ARMED: begin
          if (above_up)                state_nxt = S_ACTIVE;
          else if (quiet || bus.ilast) state_nxt = S_IDLE;
        end
        S_ACTIVE: begin
          if (quiet) begin
            cand_end_nxt = bus.iidx;
            // A quiet final sample still closes the word: the stream is over.
            if (HANG_N == 16'd1 || bus.ilast) begin
              fin       = 1'b1;
              fin_end   = bus.iidx;
              state_nxt = S_IDLE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = S_HANG;
              cnt_nxt   = 16'd1;
            end
          end else if (bus.ilast) begin
            fin       = 1'b1;
            fin_end   = bus.iidx;
            state_nxt = S_IDLE;
          end
        end
        S_HANG: begin
          if (bus.ilast) begin
            fin       = 1'b1;
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else if (quiet) begin
            cnt_nxt = cnt_q + 16'd1;
            if (cnt_q + 16'd1 == HANG_N) begin
              fin       = 1'b1;
              state_nxt = S_IDLE;
              cnt_nxt   = '0;
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = S_ACTIVE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Finalize datapath: length check and start padding (borrow means saturate).
  always_comb begin : finalize_outputs
    raw_len   = fin_end - start_q + IDX_W'(1);
    pad_diff  = {1'b0, start_q} - {1'b0, PRE_N};
    pad_start = pad_diff[IDX_W] ? '0 : pad_diff[IDX_W-1:0];
    load      = fin && (raw_len >= MIN_N);
    reject    = fin && (raw_len < MIN_N);
  end

  // Result register: a load wins when the slot is empty or draining this cycle.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      ovalid_q    <= 1'b0;
      ostart_q    <= '0;
      oend_q      <= '0;
      olen_q      <= '0;
      oshort_q    <= 1'b0;
      ooverflow_q <= 1'b0;
    end else begin
      oshort_q <= reject;
      if (load) begin
        if (!ovalid_q || bus.iready) begin
          ovalid_q <= 1'b1;
          ostart_q <= pad_start;
          oend_q   <= fin_end;
          olen_q   <= fin_end - pad_start + IDX_W'(1);
        end else begin
          ooverflow_q <= 1'b1;
        end
      end else if (ovalid_q && bus.iready) begin
        ovalid_q <= 1'b0;
      end
    end
  end

  assign bus.ovalid     = ovalid_q;
  assign bus.ostart_idx = ostart_q;
  assign bus.oend_idx   = oend_q;
  assign bus.olen       = olen_q;
  assign bus.oshort     = oshort_q;
  assign bus.ooverflow  = ooverflow_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_word_segmenter.sv
// Bench for word_segmenter: directed scenarios plus random streams checked
// against a quiet-run based reference model.
module tb_word_segmenter;
  localparam int          DATA_W = 16;
  localparam int          IDX_W  = 32;
  localparam int          HANG   = 4;
  localparam int          MINL   = 8;
  localparam int          PRE    = 2;
  localparam int          LO     = 'h42;
  localparam int          UP     = 'h294;
  localparam int          RW     = 3 * IDX_W;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } smp_t;

  // ---------------- clock / reset ----------------
  logic iclk = 1'b0;
  logic irst;
  always #5 iclk = ~iclk;

  word_segmenter_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  word_segmenter #(
    .DATA_W(DATA_W), .IDX_W(IDX_W), .SIGNED(1'b1),
    .LOWER_THRESHOLD(16'h0042), .UPPER_THRESHOLD(16'h0294),
    .HANGOVER(HANG), .MIN_LEN(MINL), .PRE_ROLL(PRE)
  ) dut (
    .iclk(iclk),
    .irst(irst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] obs_q[$];
  int exp_short;
  int short_seen;
  smp_t stim[$];

  // ---------------- monitor ----------------
  always @(negedge iclk) begin
    if (!irst) begin
      if (bus.ovalid && bus.iready)
        obs_q.push_back({bus.ostart_idx, bus.oend_idx, bus.olen});
      if (bus.oshort) short_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data,
                      input logic last);
    bus.ivalid = 1'b1;
    bus.iidx   = idx;
    bus.idata  = data;
    bus.ilast  = last;
    @(posedge iclk); #1;
    bus.ivalid = 1'b0;
    bus.ilast  = 1'b0;
    bus.idata  = DATA_W'($urandom);
  endtask

  // Bubble cycles carry junk data and ilast to show they are ignored.
  task automatic idle(input int n);
    repeat (n) begin
      bus.ivalid = 1'b0;
      bus.ilast  = 1'($urandom_range(0, 1));
      bus.idata  = DATA_W'($urandom);
      @(posedge iclk); #1;
    end
    bus.ilast = 1'b0;
  endtask

  task automatic send_run(input int first, input int last_idx, input logic [DATA_W-1:0] data);
    for (int i = first; i <= last_idx; i++) send(IDX_W'(i), data, 1'b0);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    short_seen = 0;
  endtask

  // ---------------- reference model ----------------
  function automatic int mag_of(input logic [DATA_W-1:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  // A word starts at the first sample above LO, is confirmed by a sample above UP
  // before any quiet or last sample, and ends at the first sample of a quiet run of
  // HANG samples, at the first sample of the quiet run cut by last, or at a loud last.
  task automatic model_stream();
    int n, i, k, m, run;
    logic confirmed, done;
    logic [IDX_W-1:0] st, en, raw, ps;
    n = stim.size();
    i = 0;
    exp_q.delete();
    exp_short = 0;
    while (i < n) begin
      if (mag_of(stim[i].data) <= LO) begin
        i++;
        continue;
      end
      st = stim[i].idx;
      k = i;
      confirmed = (mag_of(stim[i].data) > UP);
      if (!confirmed) begin
        k = i + 1;
        while (k < n) begin
          if (mag_of(stim[k].data) > UP) begin
            confirmed = 1'b1;
            break;
          end
          if (mag_of(stim[k].data) < LO || stim[k].last) break;
          k++;
        end
      end
      if (!confirmed) begin
        i = k + 1;
        continue;
      end
      done = 1'b0;
      run = -1;
      en = '0;
      m = k + 1;
      while (m < n && !done) begin
        if (mag_of(stim[m].data) < LO) begin
          if (run < 0) run = m;
          if (m - run + 1 == HANG || stim[m].last) begin
            en = stim[run].idx;
            done = 1'b1;
          end
        end else begin
          if (stim[m].last) begin
            en = stim[m].idx;
            done = 1'b1;
          end
          run = -1;
        end
        if (!done) m++;
      end
      if (done) begin
        raw = en - st + 1;
        if (raw < MINL) exp_short++;
        else begin
          ps = (st >= PRE) ? st - PRE : '0;
          exp_q.push_back({ps, en, en - ps + 1});
        end
      end
      i = m + 1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    irst = 1'b1;
    #12;
    n_cmp++; if (bus.ovalid !== 1'b0) begin n_err++; $display("FAIL reset_ovalid: got %b want 0", bus.ovalid); end
    n_cmp++; if (bus.ostart_idx !== '0) begin n_err++; $display("FAIL reset_ostart: got %0d want 0", bus.ostart_idx); end
    n_cmp++; if (bus.oend_idx !== '0) begin n_err++; $display("FAIL reset_oend: got %0d want 0", bus.oend_idx); end
    n_cmp++; if (bus.olen !== '0) begin n_err++; $display("FAIL reset_olen: got %0d want 0", bus.olen); end
    n_cmp++; if (bus.oshort !== 1'b0) begin n_err++; $display("FAIL reset_oshort: got %b want 0", bus.oshort); end
    n_cmp++; if (bus.ooverflow !== 1'b0) begin n_err++; $display("FAIL reset_ooverflow: got %b want 0", bus.ooverflow); end
    @(negedge iclk);
    irst = 1'b0;
    @(posedge iclk); #1;
  endtask

  task automatic test_basic();
    clear_obs();
    send_run(0, 9, 16'h0010);
    send_run(10, 29, 16'h0300);
    send_run(30, 39, 16'h0010);
    idle(3);
    n_cmp++; if (obs_q.size() !== 1) begin n_err++; $display("FAIL basic_count: got %0d want 1", obs_q.size()); end
    else begin
      n_cmp++;
      if (obs_q[0] !== {32'd8, 32'd30, 32'd23}) begin
        n_err++; $display("FAIL basic_word: got %h want %h", obs_q[0], {32'd8, 32'd30, 32'd23});
      end
    end
    n_cmp++; if (short_seen !== 0) begin n_err++; $display("FAIL basic_short: got %0d want 0", short_seen); end
    n_cmp++; if (bus.ovalid !== 1'b0) begin n_err++; $display("FAIL basic_drained: got %b want 0", bus.ovalid); end
  endtask

  task automatic test_bridge();
    clear_obs();
    send_run(0, 9, 16'h0010);
    send_run(10, 19, 16'h0300);
    send_run(20, 22, 16'h0010);
    send_run(23, 29, 16'h0100);
    send_run(30, 35, 16'h0010);
    idle(3);
    n_cmp++; if (obs_q.size() !== 1) begin n_err++; $display("FAIL bridge_count: got %0d want 1", obs_q.size()); end
    else begin
      n_cmp++;
      if (obs_q[0] !== {32'd8, 32'd30, 32'd23}) begin
        n_err++; $display("FAIL bridge_word: got %h want %h", obs_q[0], {32'd8, 32'd30, 32'd23});
      end
    end
  endtask

  task automatic test_short_and_abort();
    clear_obs();
    send_run(0, 4, 16'h0010);
    send_run(5, 7, 16'hFD00);          // -0x300
    send_run(8, 15, 16'h0010);
    idle(3);
    n_cmp++; if (short_seen !== 1) begin n_err++; $display("FAIL short_pulse: got %0d want 1", short_seen); end
    n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL short_noword: got %0d want 0", obs_q.size()); end
    clear_obs();
    send_run(40, 45, 16'h0050);
    send_run(46, 50, 16'h0010);
    send_run(60, 62, 16'hFF00);        // -0x100: between thresholds, not upper
    send_run(63, 70, 16'h0010);
    idle(3);
    n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL armed_noword: got %0d want 0", obs_q.size()); end
    n_cmp++; if (short_seen !== 0) begin n_err++; $display("FAIL armed_noshort: got %0d want 0", short_seen); end
  endtask

  task automatic test_last_and_saturation();
    clear_obs();
    send_run(0, 19, 16'h0300);
    send(32'd20, 16'h0300, 1'b1);
    idle(2);
    send_run(100, 109, 16'h8000);
    send_run(110, 115, 16'h0000);
    idle(3);
    n_cmp++; if (obs_q.size() !== 2) begin n_err++; $display("FAIL last_count: got %0d want 2", obs_q.size()); end
    else begin
      n_cmp++;
      if (obs_q[0] !== {32'd0, 32'd20, 32'd21}) begin
        n_err++; $display("FAIL last_sat_word: got %h want %h", obs_q[0], {32'd0, 32'd20, 32'd21});
      end
      n_cmp++;
      if (obs_q[1] !== {32'd98, 32'd110, 32'd13}) begin
        n_err++; $display("FAIL negmax_word: got %h want %h", obs_q[1], {32'd98, 32'd110, 32'd13});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] a;
    a = {32'd8, 32'd30, 32'd23};
    clear_obs();
    bus.iready = 1'b0;
    send_run(0, 9, 16'h0010);
    send_run(10, 29, 16'h0300);
    send_run(30, 33, 16'h0010);
    n_cmp++; if (bus.ovalid !== 1'b1) begin n_err++; $display("FAIL bp_first_valid: got %b want 1", bus.ovalid); end
    send_run(34, 39, 16'h0010);
    send_run(40, 59, 16'h0300);
    send_run(60, 63, 16'h0010);
    idle(2);
    n_cmp++; if (bus.ooverflow !== 1'b1) begin n_err++; $display("FAIL bp_overflow: got %b want 1", bus.ooverflow); end
    n_cmp++; if ({bus.ostart_idx, bus.oend_idx, bus.olen} !== a) begin
      n_err++; $display("FAIL bp_hold: got %h want %h", {bus.ostart_idx, bus.oend_idx, bus.olen}, a);
    end
    n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL bp_no_transfer: got %0d want 0", obs_q.size()); end
    bus.iready = 1'b1;
    idle(2);
    n_cmp++; if (obs_q.size() !== 1) begin n_err++; $display("FAIL bp_deliver_count: got %0d want 1", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[0] !== a) begin n_err++; $display("FAIL bp_deliver: got %h want %h", obs_q[0], a); end
    end
    n_cmp++; if (bus.ovalid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", bus.ovalid); end
    n_cmp++; if (bus.ooverflow !== 1'b1) begin n_err++; $display("FAIL bp_sticky: got %b want 1", bus.ooverflow); end
  endtask

  task automatic test_async_reset();
    clear_obs();
    bus.iready = 1'b0;
    send_run(0, 9, 16'h0010);
    send_run(10, 29, 16'h0300);
    send_run(30, 39, 16'h0010);
    send_run(40, 50, 16'h0300);        // mid-word, result register still full
    #3;
    irst = 1'b1;
    #1;
    n_cmp++; if (bus.ovalid !== 1'b0) begin n_err++; $display("FAIL arst_ovalid: got %b want 0", bus.ovalid); end
    n_cmp++; if ({bus.ostart_idx, bus.oend_idx, bus.olen} !== '0) begin
      n_err++; $display("FAIL arst_data: got %h want 0", {bus.ostart_idx, bus.oend_idx, bus.olen});
    end
    n_cmp++; if (bus.oshort !== 1'b0) begin n_err++; $display("FAIL arst_oshort: got %b want 0", bus.oshort); end
    n_cmp++; if (bus.ooverflow !== 1'b0) begin n_err++; $display("FAIL arst_ooverflow: got %b want 0", bus.ooverflow); end
    repeat (2) @(posedge iclk);
    #2;
    irst = 1'b0;
    bus.iready = 1'b1;
    clear_obs();
    send_run(200, 209, 16'h0010);
    send_run(210, 229, 16'h0300);
    send_run(230, 235, 16'h0010);
    idle(3);
    n_cmp++; if (obs_q.size() !== 1) begin n_err++; $display("FAIL arst_after_count: got %0d want 1", obs_q.size()); end
    else begin
      n_cmp++;
      if (obs_q[0] !== {32'd208, 32'd230, 32'd23}) begin
        n_err++; $display("FAIL arst_after_word: got %h want %h", obs_q[0], {32'd208, 32'd230, 32'd23});
      end
    end
  endtask

  task automatic build_stream(input int base);
    int nseg, typ, len, m;
    logic [DATA_W-1:0] d;
    logic [IDX_W-1:0] idx;
    stim.delete();
    idx = IDX_W'(base);
    nseg = $urandom_range(3, 8);
    for (int s = 0; s < nseg; s++) begin
      typ = $urandom_range(0, 2);
      len = (typ == 2) ? $urandom_range(1, 20) : (typ == 1) ? $urandom_range(1, 8) : $urandom_range(1, 7);
      for (int j = 0; j < len; j++) begin
        if (typ == 0)      m = ($urandom_range(0, 3) == 0) ? 'h41 : $urandom_range(0, 'h41);
        else if (typ == 1) m = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? LO : UP)
                                                           : $urandom_range('h42, 'h294);
        else               m = $urandom_range('h295, 'h7fff);
        d = DATA_W'(m);
        if ($urandom_range(0, 1) == 1) d = -d;
        if (typ == 2 && $urandom_range(0, 15) == 0) d = 16'h8000;
        stim.push_back('{idx, d, 1'b0});
        idx++;
      end
    end
    stim.push_back('{idx, 16'h0000, 1'b0});
    idx++;
    stim.push_back('{idx, 16'h0000, 1'b1});
  endtask

  task automatic test_random();
    bus.iready = 1'b1;
    for (int r = 0; r < 12; r++) begin
      build_stream($urandom_range(0, 6));
      model_stream();
      clear_obs();
      foreach (stim[i]) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send(stim[i].idx, stim[i].data, stim[i].last);
      end
      idle(4);
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin
        n_err++; $display("FAIL rand_count[%0d]: got %0d want %0d", r, obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          n_cmp++;
          if (obs_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL rand_word[%0d.%0d]: got %h want %h", r, i, obs_q[i], exp_q[i]);
          end
        end
      end
      n_cmp++;
      if (short_seen !== exp_short) begin
        n_err++; $display("FAIL rand_short[%0d]: got %0d want %0d", r, short_seen, exp_short);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.ivalid = 1'b0;
    bus.ilast  = 1'b0;
    bus.iidx   = '0;
    bus.idata  = '0;
    bus.iready = 1'b1;
    short_seen = 0;
    exp_short  = 0;
    test_reset();
    test_basic();
    test_bridge();
    test_short_and_abort();
    test_last_and_saturation();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
